// File: rtl/x_debounce_pkg.sv
// Shared definitions for the x_debounce input conditioner: state encodings
// and the default stability-counter width.
package x_debounce_pkg;

    typedef enum logic [1:0] {
        LO_IDLE = 2'd0,
        CHK_HI  = 2'd1,
        HI_IDLE = 2'd2,
        CHK_LO  = 2'd3
    } state_t;

    localparam int unsigned CNT_BITS_DEFAULT = 8;

endpackage : x_debounce_pkg

// File: rtl/x_sync2.sv
// Two-flop synchronizer for a single asynchronous level, async active-low reset.
module x_sync2 (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule : x_sync2

// File: rtl/x_debounce.sv
// Debouncer: synchronizes d, then requires stable_cnt+2 steady samples before q follows.
// Optional saturating glitch counter enabled by macro X_DEBOUNCE_GLITCH_CNT_EN.
module x_debounce
    import x_debounce_pkg::*;
#(
    parameter int unsigned CNT_BITS = CNT_BITS_DEFAULT
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                d,
    input  logic [CNT_BITS-1:0] stable_cnt,
`ifdef X_DEBOUNCE_GLITCH_CNT_EN
    input  logic                glitch_clr,
    output logic [7:0]          glitch_cnt,
`endif
    output logic                q
);

    logic                ds;
    logic [CNT_BITS-1:0] cnt;
    state_t              state;

    x_sync2 u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (d),
        .q       (ds)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= LO_IDLE;
            cnt   <= '0;
            q     <= 1'b0;
        end else begin
            case (state)
                LO_IDLE: begin
                    if (ds) begin
                        state <= CHK_HI;
                        cnt   <= '0;
                    end
                end
                CHK_HI: begin
                    if (!ds) begin
                        state <= LO_IDLE;
                    end else if (cnt == stable_cnt) begin
                        state <= HI_IDLE;
                        q     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HI_IDLE: begin
                    if (!ds) begin
                        state <= CHK_LO;
                        cnt   <= '0;
                    end
                end
                CHK_LO: begin
                    if (ds) begin
                        state <= HI_IDLE;
                    end else if (cnt == stable_cnt) begin
                        state <= LO_IDLE;
                        q     <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= LO_IDLE;
                    q     <= 1'b0;
                end
            endcase
        end
    end

`ifdef X_DEBOUNCE_GLITCH_CNT_EN
    logic glitch_exit;

    always_comb begin
        glitch_exit = ((state == CHK_HI) && !ds) || ((state == CHK_LO) && ds);
    end

    // Clear wins over a coincident increment; the count holds at 255.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            glitch_cnt <= '0;
        end else if (glitch_clr) begin
            glitch_cnt <= '0;
        end else if (glitch_exit && (glitch_cnt != 8'hFF)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end
`endif

endmodule : x_debounce
